// File: rtl/jtag_tap_core.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_tap_core
//  Description : IEEE 1149.1 TAP controller. Contains the 16-state TAP FSM,
//                the instruction register, the IDCODE and BYPASS data
//                registers and the TDO mux. Decodes the latched instruction
//                into one-hot selects for N user DR chains and drives shared
//                capture/shift/update strobes to them.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_core #(
  parameter int unsigned IR_WIDTH   = 5,
  parameter int unsigned N_CHAINS   = 2,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int unsigned IDCODE_OP  = 1,
  parameter int unsigned USER_BASE  = 16
) (
  input  logic                tck,
  input  logic                trst,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic                tlr,
  output logic [N_CHAINS-1:0] chain_sel,
  input  logic [N_CHAINS-1:0] chain_tdo,
  output logic                capture_dr,
  output logic                shift_dr,
  output logic                update_dr,
  output logic [IR_WIDTH-1:0] ir_out
);

  // --------------------------------------------------------------------------
  // TAP state encoding
  // --------------------------------------------------------------------------
  localparam logic [3:0] c_TLR    = 4'd0;
  localparam logic [3:0] c_RTI    = 4'd1;
  localparam logic [3:0] c_SEL_DR = 4'd2;
  localparam logic [3:0] c_CAP_DR = 4'd3;
  localparam logic [3:0] c_SH_DR  = 4'd4;
  localparam logic [3:0] c_EX1_DR = 4'd5;
  localparam logic [3:0] c_PAU_DR = 4'd6;
  localparam logic [3:0] c_EX2_DR = 4'd7;
  localparam logic [3:0] c_UPD_DR = 4'd8;
  localparam logic [3:0] c_SEL_IR = 4'd9;
  localparam logic [3:0] c_CAP_IR = 4'd10;
  localparam logic [3:0] c_SH_IR  = 4'd11;
  localparam logic [3:0] c_EX1_IR = 4'd12;
  localparam logic [3:0] c_PAU_IR = 4'd13;
  localparam logic [3:0] c_EX2_IR = 4'd14;
  localparam logic [3:0] c_UPD_IR = 4'd15;

  // Instruction constants, sized to the IR
  localparam logic [IR_WIDTH-1:0] c_IDCODE_OP  = IR_WIDTH'(IDCODE_OP);
  localparam logic [IR_WIDTH-1:0] c_IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

  logic [3:0]          state_q;
  logic [3:0]          state_d;
  logic [IR_WIDTH-1:0] ir_sh_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic [31:0]         idcode_q;
  logic                bypass_q;
  logic                tdo_q;
  logic                tdo_en_q;

  logic                w_sel_idcode;
  logic                w_any_user;
  logic                w_sel_bypass;
  logic                w_chain_bit;
  logic                w_dr_bit;
  logic [N_CHAINS-1:0] w_chain_sel;

  // --------------------------------------------------------------------------
  // TAP FSM: 1149.1 TMS transition graph
  // --------------------------------------------------------------------------
  // Next-state decode from the current state and TMS
  always_comb begin
    state_d = c_TLR;
    case (state_q)
      c_TLR:    state_d = tms ? c_TLR    : c_RTI;
      c_RTI:    state_d = tms ? c_SEL_DR : c_RTI;
      c_SEL_DR: state_d = tms ? c_SEL_IR : c_CAP_DR;
      c_CAP_DR: state_d = tms ? c_EX1_DR : c_SH_DR;
      c_SH_DR:  state_d = tms ? c_EX1_DR : c_SH_DR;
      c_EX1_DR: state_d = tms ? c_UPD_DR : c_PAU_DR;
      c_PAU_DR: state_d = tms ? c_EX2_DR : c_PAU_DR;
      c_EX2_DR: state_d = tms ? c_UPD_DR : c_SH_DR;
      c_UPD_DR: state_d = tms ? c_SEL_DR : c_RTI;
      c_SEL_IR: state_d = tms ? c_TLR    : c_CAP_IR;
      c_CAP_IR: state_d = tms ? c_EX1_IR : c_SH_IR;
      c_SH_IR:  state_d = tms ? c_EX1_IR : c_SH_IR;
      c_EX1_IR: state_d = tms ? c_UPD_IR : c_PAU_IR;
      c_PAU_IR: state_d = tms ? c_EX2_IR : c_PAU_IR;
      c_EX2_IR: state_d = tms ? c_UPD_IR : c_SH_IR;
      c_UPD_IR: state_d = tms ? c_SEL_DR : c_RTI;
      default:  state_d = c_TLR;
    endcase
  end

  // State register, advanced on the rising test clock
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      state_q <= c_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction register
  // --------------------------------------------------------------------------
  // IR shift stage: capture the fixed 0..01 pattern, then shift LSB-first
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_sh_q <= '0;
    end else if (state_q == c_CAP_IR) begin
      ir_sh_q <= c_IR_CAPTURE;
    end else if (state_q == c_SH_IR) begin
      ir_sh_q <= {tdi, ir_sh_q[IR_WIDTH-1:1]};
    end
  end

  // Latched IR: updated on the falling edge in Update-IR, forced in TLR.
  // The asynchronous reset ensures a trst mid-shift never exposes partial data.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      ir_q <= c_IDCODE_OP;
    end else if (state_q == c_TLR) begin
      ir_q <= c_IDCODE_OP;
    end else if (state_q == c_UPD_IR) begin
      ir_q <= ir_sh_q;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction decode. IDCODE takes precedence over a user opcode that
  // happens to alias it; anything unrecognised falls through to BYPASS.
  // --------------------------------------------------------------------------
  assign w_sel_idcode = (ir_q == c_IDCODE_OP);

  for (genvar k = 0; k < int'(N_CHAINS); k++) begin : g_chain_sel
    assign w_chain_sel[k] = (ir_q == IR_WIDTH'(USER_BASE + k)) && !w_sel_idcode;
  end

  assign w_any_user   = |w_chain_sel;
  assign w_sel_bypass = !w_sel_idcode && !w_any_user;
  assign w_chain_bit  = |(w_chain_sel & chain_tdo);

  // --------------------------------------------------------------------------
  // Built-in data registers
  // --------------------------------------------------------------------------
  // IDCODE register: capture the device ID, shift right with tdi into bit 31
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      idcode_q <= IDCODE_VAL;
    end else if (w_sel_idcode && (state_q == c_CAP_DR)) begin
      idcode_q <= IDCODE_VAL;
    end else if (w_sel_idcode && (state_q == c_SH_DR)) begin
      idcode_q <= {tdi, idcode_q[31:1]};
    end
  end

  // BYPASS register: single bit, cleared in capture, follows tdi in shift
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      bypass_q <= 1'b0;
    end else if (w_sel_bypass && (state_q == c_CAP_DR)) begin
      bypass_q <= 1'b0;
    end else if (w_sel_bypass && (state_q == c_SH_DR)) begin
      bypass_q <= tdi;
    end
  end

  // --------------------------------------------------------------------------
  // TDO mux, retimed to the falling edge so the pin is stable at the next
  // rising edge seen by the external probe.
  // --------------------------------------------------------------------------
  assign w_dr_bit = w_sel_idcode ? idcode_q[0] :
                    w_any_user   ? w_chain_bit : bypass_q;

  // Output stage: present the active register LSB only while shifting
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_en_q <= (state_q == c_SH_IR) || (state_q == c_SH_DR);
      if (state_q == c_SH_IR) begin
        tdo_q <= ir_sh_q[0];
      end else if (state_q == c_SH_DR) begin
        tdo_q <= w_dr_bit;
      end else begin
        tdo_q <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Strobes are plain state decodes, muted when no user chain is
  // selected so the external chains never move during IDCODE/BYPASS access.
  // --------------------------------------------------------------------------
  assign tdo        = tdo_q;
  assign tdo_en     = tdo_en_q;
  assign tlr        = (state_q == c_TLR);
  assign chain_sel  = w_chain_sel;
  assign capture_dr = (state_q == c_CAP_DR) && w_any_user;
  assign shift_dr   = (state_q == c_SH_DR)  && w_any_user;
  assign update_dr  = (state_q == c_UPD_DR) && w_any_user;
  assign ir_out     = ir_q;

endmodule
`default_nettype wire

// File: doc/jtag_tap_core.md
# jtag_tap_core

Parametrised IEEE 1149.1 TAP core: full 16-state TAP FSM, instruction register, IDCODE and BYPASS data registers, and TDO mux, all in one block. It decodes the instruction into one-hot selects for N user data chains and drives shared capture, shift and update strobes to them. It sits between the chip JTAG pins and the debug-side DR chains.

## Interface
- IR_WIDTH, 5: instruction register width, ≥2.
- N_CHAINS, 2: number of user DR chains, 1..(2^IR_WIDTH−2).
- IDCODE_VAL, 32'h1000_0001: IDCODE DR contents; bit 0 must be 1.
- IDCODE_OP, 1: IDCODE opcode.
- USER_BASE, 16: opcode of user chain 0; chain k uses USER_BASE+k.
- BYPASS is fixed at all-ones.

Ports:
- tck  in  1  test clock.
- trst  in  1  reset; asynchronous, active-low.
- tms  in  1  mode select, sampled posedge tck.
- tdi  in  1  serial in, sampled posedge tck.
- tdo  out  1  serial out, changes on negedge tck.
- tdo_en  out  1  tdo valid/drive enable, changes on negedge tck.
- tlr  out  1  high in Test-Logic-Reset.
- chain_sel  out  N_CHAINS  one-hot user chain select, decoded from the latched IR.
- chain_tdo  in  N_CHAINS  serial out of each user chain.
- capture_dr / shift_dr / update_dr  out  1 each  DR-state levels, qualified by any chain_sel bit.
- ir_out  out  IR_WIDTH  latched instruction.

## Operation
- The FSM has the standard 16 states: TLR, RTI, Select-DR, Capture-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Update-DR, and the same seven for IR.
- Transitions follow the 1149.1 TMS graph on posedge tck.
- Five consecutive TMS=1 edges reach TLR from any state.
- The IR shift register is IR_WIDTH bits.
  - Capture-IR loads {0…0,0,1}.
  - Shift-IR shifts right, LSB out first, with tdi entering the MSB.
  - The latched IR loads on negedge tck while in Update-IR.
  - In TLR the latched IR is forced to IDCODE_OP.
- DR selection, by latched IR value:
  - IDCODE_OP selects the 32-bit IDCODE register.
  - USER_BASE+k with k<N_CHAINS selects user chain k.
  - All-ones and every other value select the 1-bit BYPASS register.
- The IDCODE register loads IDCODE_VAL in Capture-DR and shifts right with tdi into bit 31.
- The BYPASS register loads 0 in Capture-DR and loads tdi in Shift-DR.
- User chains hold their own shift registers. The core supplies only strobes and sel and muxes chain_tdo.
- TDO source:
  - Shift-IR: IR shift LSB.
  - Shift-DR: the selected DR's LSB or chain_tdo[k].
  - Otherwise tdo holds 0.
- tdo_en is high only on the negedge following entry to Shift-IR or Shift-DR, and drops on the negedge after leaving.
- capture_dr, shift_dr and update_dr are combinational decodes of the current state, gated to 0 when no user chain is selected.
- Reset values, trst low:
  - state=TLR, IR shift=0, latched IR=IDCODE_OP, IDCODE reg=IDCODE_VAL, bypass=0.
  - tdo=0, tdo_en=0, tlr=1, chain_sel=0, strobes=0, ir_out=IDCODE_OP.
- trst mid-shift aborts immediately. The latched IR is not updated with partial shift data.

## Timing
- State register updates on posedge tck. tdo and tdo_en update on negedge tck, i.e. half a cycle after the state change.
- A user chain samples tdi on posedge tck while shift_dr && chain_sel[k]. It loads parallel data on posedge tck while capture_dr && chain_sel[k].
- update_dr is high for exactly the one tck cycle spent in Update-DR. Chains latch on the posedge that leaves Update-DR.
- chain_sel changes only on the negedge in Update-IR or on entry to TLR. It never changes during DR states.
- DR path latency, Capture-DR to first bit on tdo:
  - On entering Shift-DR, tdo presents bit 0 at the following negedge.
  - The n-bit register is fully shifted after n posedges in Shift-DR, including the Exit1 transition edge.
- Pause states hold all shift registers unchanged, with tdo_en=0.

## Test plan
- trst low, release, 32 tck with TMS sequence 0,1,0,0 then 31×0 and 1 (to Exit1-DR) -> tdo shows 32'h1000_0001 LSB first; tdo_en is high for exactly 32 negedges.
- From RTI, go to Shift-IR and shift 5 bits of 5'b11111 -> tdo reads 1,0,0,0,0; after Update-IR, ir_out=5'h1F and chain_sel=0.
- BYPASS active, shift pattern 1,0,1,1 -> tdo reproduces it delayed by one cycle, preceded by a single 0.
- Load IR=16 and shift 8 bits -> chain_sel=2'b01; shift_dr high 8 cycles; tdo follows chain_tdo[0]; update_dr pulses exactly 1 cycle. Repeat with IR=17 and chain_sel=2'b10. IR=18 -> bypass, strobes stay 0.
- From Pause-IR, TMS=1 for 5 edges -> tlr=1, ir_out=IDCODE_OP, tdo_en=0.
- Assert trst at the 3rd Shift-IR edge after loading IR=16 -> ir_out returns to IDCODE_OP asynchronously; chain_sel=0, tdo_en=0, tdo=0.
